// File: rtl/axi_wdma.sv
// rtl/axi_wdma.sv - AXI4 write DMA: streams aligned dwords to memory as 4 KB-safe INCR bursts
module axi_wdma #(
    parameter int ADDRESS_BITS = 32,
    parameter int LENGTH_BITS  = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [ADDRESS_BITS-1:0] cmd_address,
    input  logic [LENGTH_BITS-1:0]  cmd_bytes,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,

    output logic [3:0]              axi_m_awid,
    output logic [ADDRESS_BITS-1:0] axi_m_awaddr,
    output logic [7:0]              axi_m_awlen,
    output logic [2:0]              axi_m_awsize,
    output logic [1:0]              axi_m_awburst,
    output logic                    axi_m_awvalid,
    input  logic                    axi_m_awready,

    output logic [31:0]             axi_m_wdata,
    output logic [3:0]              axi_m_wstrb,
    output logic                    axi_m_wlast,
    output logic                    axi_m_wvalid,
    input  logic                    axi_m_wready,

    input  logic [3:0]              axi_m_bid,
    input  logic [1:0]              axi_m_bresp,
    input  logic                    axi_m_bvalid,
    output logic                    axi_m_bready,

    input  logic [31:0]             din_tdata,
    input  logic [3:0]              din_tkeep,
    input  logic                    din_tlast,
    input  logic                    din_tvalid,
    output logic                    din_tready,

    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CALC,
        S_AW,
        S_DATA,
        S_INCR,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [ADDRESS_BITS-1:0] cmd_addr_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [LENGTH_BITS-1:0]  cmd_bytes_q;
    logic [LENGTH_BITS-1:0]  remaining_q;
    logic [LENGTH_BITS-1:0]  outstanding_q;
    logic [8:0]              beats_q;
    logic [8:0]              beat_cnt_q;
    logic [7:0]              awlen_q;
    logic [3:0]              first_mask_q;
    logic [3:0]              last_mask_q;
    logic                    first_pend_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    last_beat;
    logic                    last_burst;
    logic [LENGTH_BITS:0]    span;
    logic [LENGTH_BITS-1:0]  total_dwords;
    logic [LENGTH_BITS-1:0]  rem_next;
    logic [10:0]             room;
    logic [8:0]              burst_cap;
    logic [8:0]              beats_n;
    logic [1:0]              end_lane;
    logic                    unused_inputs;

    assign unused_inputs = ^{axi_m_bid, din_tkeep, din_tlast};

    assign axi_m_awid    = 4'd0;
    assign axi_m_awsize  = 3'b010;
    assign axi_m_awburst = 2'b01;
    assign axi_m_bready  = 1'b1;
    assign axi_m_awaddr  = addr_q;
    assign axi_m_awlen   = awlen_q;
    assign axi_m_wdata   = din_tdata;

    assign aw_hs = axi_m_awvalid && axi_m_awready;
    assign w_hs  = axi_m_wvalid && axi_m_wready;
    assign b_hs  = axi_m_bvalid;

    // Bytes spanned from the aligned base, rounded up to whole dwords.
    assign span = {1'b0, cmd_bytes_q}
                + {{(LENGTH_BITS-1){1'b0}}, cmd_addr_q[1:0]}
                + (LENGTH_BITS+1)'(3);
    assign total_dwords = (cmd_bytes_q == '0) ? '0 : {1'b0, span[LENGTH_BITS:2]};

    // Dwords left before the next 4 KB page, capped at the AXI4 burst limit.
    assign room      = 11'd1024 - {1'b0, addr_q[11:2]};
    assign burst_cap = (room > 11'd256) ? 9'd256 : room[8:0];
    assign beats_n   = (remaining_q < LENGTH_BITS'(burst_cap)) ? remaining_q[8:0] : burst_cap;
    assign rem_next  = remaining_q - LENGTH_BITS'(beats_q);

    assign end_lane   = cmd_addr_q[1:0] + cmd_bytes_q[1:0];
    assign last_beat  = (beat_cnt_q == {1'b0, awlen_q});
    assign last_burst = (remaining_q == LENGTH_BITS'(beats_q));

    assign axi_m_wlast = last_beat;
    assign axi_m_wstrb = (first_pend_q ? first_mask_q : 4'b1111)
                       & ((last_burst && last_beat) ? last_mask_q : 4'b1111);

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        axi_m_awvalid = 1'b0;
        axi_m_wvalid  = 1'b0;
        din_tready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_INIT;
            end
            S_INIT: state_d = (total_dwords != '0) ? S_CALC : S_WAIT;
            S_CALC: state_d = S_AW;
            S_AW: begin
                axi_m_awvalid = 1'b1;
                if (axi_m_awready) state_d = S_DATA;
            end
            S_DATA: begin
                axi_m_wvalid = din_tvalid;
                din_tready   = axi_m_wready;
                if (w_hs && last_beat) state_d = S_INCR;
            end
            S_INCR: state_d = (rem_next != '0) ? S_CALC : S_WAIT;
            S_WAIT: if (outstanding_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_addr_q   <= '0;
            cmd_bytes_q  <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            awlen_q      <= '0;
            first_mask_q <= 4'b1111;
            last_mask_q  <= 4'b1111;
            first_pend_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_addr_q  <= cmd_address;
                        cmd_bytes_q <= cmd_bytes;
                    end
                end
                S_INIT: begin
                    addr_q       <= {cmd_addr_q[ADDRESS_BITS-1:2], 2'b00};
                    remaining_q  <= total_dwords;
                    first_mask_q <= 4'b1111 << cmd_addr_q[1:0];
                    // An end lane of 0 means the final dword is completely filled.
                    last_mask_q  <= (end_lane == 2'd0) ? 4'b1111 : ((4'b0001 << end_lane) - 4'b0001);
                    first_pend_q <= 1'b1;
                end
                S_CALC: begin
                    beats_q    <= beats_n;
                    awlen_q    <= 8'(beats_n - 9'd1);
                    beat_cnt_q <= '0;
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt_q   <= beat_cnt_q + 9'd1;
                        first_pend_q <= 1'b0;
                    end
                end
                S_INCR: begin
                    addr_q[ADDRESS_BITS-1:2] <= addr_q[ADDRESS_BITS-1:2] + (ADDRESS_BITS-2)'(beats_q);
                    remaining_q              <= rem_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding_q <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (aw_hs && !b_hs)      outstanding_q <= outstanding_q + 1'b1;
            else if (!aw_hs && b_hs) outstanding_q <= outstanding_q - 1'b1;

            if (state_q == S_INIT)                                 err <= 1'b0;
            else if (b_hs && axi_m_bresp[1] && state_q != S_IDLE) err <= 1'b1;

            done <= (state_q == S_WAIT) && (outstanding_q == '0);
        end
    end

endmodule

// File: doc/axi_wdma.md
AXI_WDMA -- requirements
Module: axi_wdma

Interface
REQ-001 Parameter ADDRESS_BITS, default 32, byte address width.
REQ-002 Parameter LENGTH_BITS, default 32, byte count width.
REQ-003 aclk  in  1  sole clock, all logic on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 cmd_address  in  ADDRESS_BITS  destination byte address, any alignment.
REQ-006 cmd_bytes  in  LENGTH_BITS  bytes to write.
REQ-007 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-008 axi_m_awid/awaddr/awlen/awsize/awburst  out  4/ADDRESS_BITS/8/3/2  AXI write address.
REQ-009 axi_m_awvalid / axi_m_awready  out / in  1  address handshake.
REQ-010 axi_m_wdata/wstrb/wlast/wvalid  out  32/4/1/1; axi_m_wready  in  1  write data channel.
REQ-011 axi_m_bid/bresp/bvalid  in  4/2/1; axi_m_bready  out  1  write response.
REQ-012 din_tdata/din_tkeep/din_tlast/din_tvalid  in  32/4/1/1; din_tready  out  1  input stream, lanes already aligned to memory byte lanes.
REQ-013 done  out  1  one-cycle pulse at command completion; err  out  1  status, valid with done.

Function
REQ-014 Constants: awid=0, awsize=3'b010, awburst=2'b01 (INCR), bready=1 at all times.
REQ-015 Command accepted when cmd_valid && cmd_ready; cmd_ready=1 only in S_IDLE.
REQ-016 Total dwords = ceil((cmd_bytes + cmd_address[1:0]) / 4); 0 when cmd_bytes=0; awaddr base = cmd_address with [1:0] cleared.
REQ-017 States: S_IDLE, S_INIT, S_CALC, S_AW, S_DATA, S_INCR, S_WAIT.
REQ-018 S_IDLE->S_INIT on accept; S_INIT->S_CALC if dwords>0, else S_WAIT; S_CALC->S_AW; S_AW->S_DATA on awready; S_DATA->S_INCR on burst's last W handshake; S_INCR->S_CALC if remaining>0 else S_WAIT; S_WAIT->S_IDLE when outstanding B count=0.
REQ-019 Burst beats = min(remaining, 256, 1024 - awaddr[11:2]); no burst crosses a 4 KB boundary.
REQ-020 awlen = beats-1, registered in S_CALC; awvalid=1 only in S_AW, held until awready.
REQ-021 In S_DATA: wvalid=din_tvalid, din_tready=wready, wdata=din_tdata, combinational; elsewhere wvalid=0, din_tready=0.
REQ-022 wlast=1 on final beat of each burst (per-burst beat counter), independent of din_tlast; din_tlast and din_tkeep ignored.
REQ-023 wstrb: first dword of command = first mask by cmd_address[1:0] (00:1111, 01:1110, 10:1100, 11:1000); last dword = last mask by (cmd_address+cmd_bytes)[1:0] (00:1111, 01:0001, 10:0011, 11:0111); single-dword command = AND of both; all others 1111.
REQ-024 In S_INCR: awaddr[ADDRESS_BITS-1:2] += beats, remaining -= beats.
REQ-025 Outstanding counter (LENGTH_BITS) +1 on AW handshake, -1 on bvalid; simultaneous events leave it unchanged.
REQ-026 err cleared in S_INIT, set sticky by any bvalid with bresp[1]=1 during the command.
REQ-027 done pulses exactly one cycle on S_WAIT->S_IDLE, including zero-byte commands.
REQ-028 Zero-byte command: no AW/W traffic, din_tready stays 0, done after at most 3 cycles.

Reset
REQ-029 On aresetn=0, immediately: state=S_IDLE, cmd_ready=1, awvalid=0, wvalid=0, din_tready=0, done=0, err=0, outstanding=0; other registers don't-care.
REQ-030 Reset mid-burst abandons the transfer; no resumption after release.

Verification
REQ-031 addr 0x1000, bytes 16 -> one AW awaddr 0x1000 awlen 3; 4 beats wstrb 1111, wlast on beat 4; done, err=0 after B.
REQ-032 addr 0x1001, bytes 6 -> awaddr 0x1000 awlen 1; wstrb 1110 then 0111, wlast on beat 2.
REQ-033 addr 0x1002, bytes 1 -> awlen 0, single beat wstrb 0100, wlast=1.
REQ-034 addr 0x0000, bytes 1028 -> AW 0x0000 awlen 255, then AW 0x0400 awlen 0; addr 0x0FF0, bytes 32 -> AW 0x0FF0 awlen 3, then AW 0x1000 awlen 3.
REQ-035 Two-burst command, second B bresp=2'b10 -> done with err=1; next clean command -> err=0.
REQ-036 bytes 0 -> no awvalid, done pulse; aresetn low during S_DATA -> awvalid=wvalid=din_tready=0, cmd_ready=1 same cycle.
